// File: rtl/election_controller.sv
// EVM tally sequencer: opens/closes the poll, counts one vote per handshake,
// then scans the counters one candidate per cycle to find the winner.
module election_controller #(
    parameter int NUM_CAND    = 3,
    parameter int CNT_W       = 4,
    parameter int LOCK_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             close_i,
    input  logic             vote_valid_i,
    input  logic [3:0]       vote_sel_i,
    output logic             vote_ready_o,
    output logic             vote_ack_o,
    output logic             vote_rej_o,
    output logic [1:0]       state_o,
    output logic             result_valid_o,
    output logic [3:0]       winner_cand_o,
    output logic [CNT_W-1:0] winner_votes_o,
    output logic             tie_o,
    output logic             overflow_o
);
    localparam int LW = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // state  | meaning
    // IDLE   | after reset, waiting for start_i
    // VOTING | poll open, one vote per handshake, lockout between votes
    // TALLY  | sequential max-search, one candidate per cycle
    // RESULT | winner outputs valid and held until next start_i
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VOTING = 2'd1,
        TALLY  = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt [NUM_CAND];
    logic [LW-1:0]    lockout;
    logic [3:0]       idx;
    logic [3:0]       max_idx;
    logic [CNT_W-1:0] max_cnt;
    logic             tie;

    logic [CNT_W-1:0] scan_val;
    logic [CNT_W-1:0] nxt_cnt;
    logic [3:0]       nxt_idx;
    logic             nxt_tie;
    logic             accept;
    logic             sel_ok;
    logic             last;

    assign state_o      = state;
    assign vote_ready_o = (state == VOTING) && (lockout == '0);
    assign accept       = vote_valid_i && vote_ready_o;
    assign sel_ok       = vote_sel_i < 4'(NUM_CAND);
    assign last         = idx == 4'(NUM_CAND - 1);

    // One step of the max-search; equal counts move the winner to the later index.
    always_comb begin
        scan_val = '0;
        for (int i = 0; i < NUM_CAND; i++)
            if (idx == 4'(i)) scan_val = cnt[i];
        nxt_cnt = max_cnt;
        nxt_idx = max_idx;
        nxt_tie = tie;
        if (idx == 4'd0) begin
            nxt_cnt = scan_val;
            nxt_idx = 4'd0;
            nxt_tie = 1'b0;
        end else if (scan_val > max_cnt) begin
            nxt_cnt = scan_val;
            nxt_idx = idx;
            nxt_tie = 1'b0;
        end else if (scan_val == max_cnt) begin
            nxt_idx = idx;
            nxt_tie = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            for (int i = 0; i < NUM_CAND; i++) cnt[i] <= '0;
            lockout        <= '0;
            idx            <= '0;
            max_idx        <= '0;
            max_cnt        <= '0;
            tie            <= 1'b0;
            vote_ack_o     <= 1'b0;
            vote_rej_o     <= 1'b0;
            result_valid_o <= 1'b0;
            winner_cand_o  <= '0;
            winner_votes_o <= '0;
            tie_o          <= 1'b0;
            overflow_o     <= 1'b0;
        end else begin
            vote_ack_o <= 1'b0;
            vote_rej_o <= 1'b0;
            case (state)
                IDLE, RESULT: begin
                    if (start_i) begin
                        state          <= VOTING;
                        for (int i = 0; i < NUM_CAND; i++) cnt[i] <= '0;
                        lockout        <= '0;
                        overflow_o     <= 1'b0;
                        tie_o          <= 1'b0;
                        winner_cand_o  <= '0;
                        winner_votes_o <= '0;
                        result_valid_o <= 1'b0;
                    end
                end
                VOTING: begin
                    if (lockout != '0) lockout <= lockout - 1'b1;
                    if (accept) begin
                        lockout <= LW'(LOCK_CYCLES);
                        if (sel_ok) begin
                            vote_ack_o <= 1'b1;
                            for (int i = 0; i < NUM_CAND; i++) begin
                                if (vote_sel_i == 4'(i)) begin
                                    if (cnt[i] == CNT_MAX) overflow_o <= 1'b1;
                                    else cnt[i] <= cnt[i] + 1'b1;
                                end
                            end
                        end else begin
                            vote_rej_o <= 1'b1;
                        end
                    end
                    if (close_i) begin
                        state   <= TALLY;
                        lockout <= '0;
                        idx     <= '0;
                    end
                end
                TALLY: begin
                    max_cnt <= nxt_cnt;
                    max_idx <= nxt_idx;
                    tie     <= nxt_tie;
                    idx     <= idx + 4'd1;
                    if (last) begin
                        state          <= RESULT;
                        result_valid_o <= 1'b1;
                        winner_cand_o  <= nxt_idx + 4'd1;
                        winner_votes_o <= nxt_cnt;
                        tie_o          <= nxt_tie;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_election_controller.sv
// Self-checking bench for election_controller: vector table, hand-written
// corner sequences and randomized polls against a counting model.
module tb_election_controller;
    localparam int NC   = 3;
    localparam int CW   = 4;
    localparam int LOCK = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          close_i = 1'b0;
    logic          vote_valid_i = 1'b0;
    logic [3:0]    vote_sel_i = '0;
    logic          vote_ready_o;
    logic          vote_ack_o;
    logic          vote_rej_o;
    logic [1:0]    state_o;
    logic          result_valid_o;
    logic [3:0]    winner_cand_o;
    logic [CW-1:0] winner_votes_o;
    logic          tie_o;
    logic          overflow_o;

    election_controller #(.NUM_CAND(NC), .CNT_W(CW), .LOCK_CYCLES(LOCK)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .close_i(close_i),
        .vote_valid_i(vote_valid_i), .vote_sel_i(vote_sel_i),
        .vote_ready_o(vote_ready_o), .vote_ack_o(vote_ack_o), .vote_rej_o(vote_rej_o),
        .state_o(state_o), .result_valid_o(result_valid_o),
        .winner_cand_o(winner_cand_o), .winner_votes_o(winner_votes_o),
        .tie_o(tie_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int m_cnt [NC];
    int m_ovf;

    typedef struct {
        int n;
        int sel [8];
        int cand;
        int votes;
        int tie;
    } vec_t;
    vec_t tbl [6];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NC; i++) m_cnt[i] = 0;
        m_ovf = 0;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("start_state", state_o, 1);
        check("start_ready", vote_ready_o, 1);
        check("start_cand", winner_cand_o, 0);
        check("start_votes", winner_votes_o, 0);
        check("start_tie", tie_o, 0);
        check("start_ovf", overflow_o, 0);
        check("start_rvalid", result_valid_o, 0);
        model_clear();
    endtask

    task automatic cast_vote(input int s);
        int n;
        n = 0;
        while (!vote_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", int'(n < 50), 1);
        vote_valid_i = 1'b1;
        vote_sel_i   = 4'(s);
        @(negedge clk);
        vote_valid_i = 1'b0;
        check("ack", vote_ack_o, int'(s < NC));
        check("rej", vote_rej_o, int'(s >= NC));
        check("ready_after_vote", vote_ready_o, 0);
        if (s < NC) begin
            if (m_cnt[s] == CMAX) m_ovf = 1;
            else m_cnt[s]++;
        end
    endtask

    // Close the poll, time the tally and compare the result with the model.
    task automatic finish_poll();
        int n, mx, nmax, win;
        close_i = 1'b1;
        @(negedge clk);
        close_i = 1'b0;
        n = 0;
        while (state_o == 2'd2 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("tally_len", n, NC);
        check("res_state", state_o, 3);
        check("res_valid", result_valid_o, 1);
        mx = 0;
        for (int i = 0; i < NC; i++) if (m_cnt[i] > mx) mx = m_cnt[i];
        nmax = 0;
        win = 0;
        for (int i = 0; i < NC; i++)
            if (m_cnt[i] == mx) begin
                nmax++;
                win = i + 1;
            end
        check("res_cand", winner_cand_o, win);
        check("res_votes", winner_votes_o, mx);
        check("res_tie", tie_o, int'(nmax > 1));
        check("res_ovf", overflow_o, m_ovf);
        repeat (3) @(negedge clk);
        check("res_hold_cand", winner_cand_o, win);
        check("res_hold_valid", result_valid_o, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, nack, nlow;
        int ack_t [5];
        int seq [5];
        int nv;

        tbl[0] = '{5, '{0, 1, 1, 2, 1, 0, 0, 0}, 2, 3, 0};
        tbl[1] = '{4, '{0, 2, 0, 2, 0, 0, 0, 0}, 3, 2, 1};
        tbl[2] = '{0, '{0, 0, 0, 0, 0, 0, 0, 0}, 3, 0, 1};
        tbl[3] = '{3, '{5, 1, 7, 0, 0, 0, 0, 0}, 2, 1, 0};
        tbl[4] = '{3, '{0, 0, 1, 0, 0, 0, 0, 0}, 1, 2, 0};
        tbl[5] = '{3, '{2, 1, 0, 0, 0, 0, 0, 0}, 3, 1, 1};
        model_clear();

        repeat (2) @(negedge clk);
        check("rst_state", state_o, 0);
        check("rst_ready", vote_ready_o, 0);
        check("rst_rvalid", result_valid_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_close_ignored_pre", state_o, 0);
        close_i = 1'b1;
        @(negedge clk);
        close_i = 1'b0;
        check("idle_close_ignored", state_o, 0);

        // Basic poll with valid held high: acceptances every LOCK+1 cycles.
        do_start();
        seq = '{0, 1, 1, 2, 1};
        vote_valid_i = 1'b1;
        vote_sel_i = 4'(seq[0]);
        nack = 0;
        t = 0;
        while (nack < 5 && t < 100) begin
            @(negedge clk);
            t++;
            if (vote_ack_o) begin
                ack_t[nack] = t;
                if (seq[nack] < NC) m_cnt[seq[nack]]++;
                nack++;
                if (nack < 5) vote_sel_i = 4'(seq[nack]);
                else vote_valid_i = 1'b0;
            end
        end
        vote_valid_i = 1'b0;
        check("basic_acks", nack, 5);
        check("basic_first_ack", ack_t[0], 1);
        for (int i = 1; i < 5; i++) check("basic_spacing", ack_t[i] - ack_t[i-1], LOCK + 1);
        finish_poll();
        check("basic_cand", winner_cand_o, 2);
        check("basic_votes", winner_votes_o, 3);

        // Table vectors, each as a fresh poll started from RESULT.
        for (int k = 0; k < 6; k++) begin
            do_start();
            for (int j = 0; j < tbl[k].n; j++) cast_vote(tbl[k].sel[j]);
            finish_poll();
            check("tbl_cand", winner_cand_o, tbl[k].cand);
            check("tbl_votes", winner_votes_o, tbl[k].votes);
            check("tbl_tie", tie_o, tbl[k].tie);
        end

        // Invalid index, lockout length, valid during lockout.
        do_start();
        cast_vote(5);
        vote_valid_i = 1'b1;
        vote_sel_i = 4'd0;
        nlow = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            nlow++;
            check("lock_no_ack", vote_ack_o, 0);
            check("lock_no_rej", vote_rej_o, 0);
        end
        vote_valid_i = 1'b0;
        while (!vote_ready_o && nlow < 20) begin
            @(negedge clk);
            if (!vote_ready_o) nlow++;
        end
        check("lock_len", nlow, LOCK);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("start_in_voting_ignored", state_o, 1);
        cast_vote(1);
        // Close coinciding with an accepted vote.
        while (!vote_ready_o) @(negedge clk);
        vote_valid_i = 1'b1;
        vote_sel_i = 4'd1;
        close_i = 1'b1;
        @(negedge clk);
        vote_valid_i = 1'b0;
        close_i = 1'b0;
        check("close_vote_ack", vote_ack_o, 1);
        check("close_vote_state", state_o, 2);
        check("close_vote_ready", vote_ready_o, 0);
        m_cnt[1]++;
        t = 0;
        while (state_o == 2'd2 && t < 40) begin
            t++;
            @(negedge clk);
        end
        check("close_vote_tally_len", t, NC);
        check("close_vote_cand", winner_cand_o, 2);
        check("close_vote_votes", winner_votes_o, 2);
        check("close_vote_tie", tie_o, 0);

        // Saturation, then a restart from RESULT clears everything.
        do_start();
        for (int i = 0; i < 17; i++) begin
            cast_vote(0);
            if (i == 14) check("sat_ovf_before", overflow_o, 0);
            if (i == 15) check("sat_ovf_set", overflow_o, 1);
        end
        finish_poll();
        check("sat_cand", winner_cand_o, 1);
        check("sat_votes", winner_votes_o, CMAX);
        check("sat_ovf", overflow_o, 1);
        do_start();
        finish_poll();
        check("restart_empty_votes", winner_votes_o, 0);

        // Reset in the middle of a tally.
        do_start();
        cast_vote(2);
        close_i = 1'b1;
        @(negedge clk);
        close_i = 1'b0;
        check("pre_rst_state", state_o, 2);
        rst_n = 1'b0;
        #2;
        check("midrst_state", state_o, 0);
        check("midrst_ack", vote_ack_o, 0);
        check("midrst_cand", winner_cand_o, 0);
        check("midrst_votes", winner_votes_o, 0);
        check("midrst_tie", tie_o, 0);
        check("midrst_ovf", overflow_o, 0);
        check("midrst_rvalid", result_valid_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_state", state_o, 0);
        do_start();
        finish_poll();

        // Randomized polls against the model.
        for (int p = 0; p < 10; p++) begin
            do_start();
            nv = int'($urandom_range(0, 22));
            for (int j = 0; j < nv; j++) begin
                if ($urandom_range(0, 3) == 0) cast_vote(0);
                else cast_vote(int'($urandom_range(0, 5)));
            end
            finish_poll();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
